// File: rtl/alfsr_pkg.sv
// Shared constants, FSM state type and per-length tap/length/MSB tables
// for the block-configurable Fibonacci LFSR.
package alfsr_pkg;

   localparam int BLK_W = 8;
   localparam int NBLK  = 6;
   localparam int MAXW  = BLK_W * NBLK;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

   // Tap masks indexed by cfg (L = 8*(cfg+1)); bit i set means 1-based tap i+1.
   function automatic logic [MAXW-1:0] tap_mask(input logic [2:0] cfg);
      case (cfg)
         3'd0:    tap_mask = 48'h0000_0000_00B8;
         3'd1:    tap_mask = 48'h0000_0000_D008;
         3'd2:    tap_mask = 48'h0000_00E1_0000;
         3'd3:    tap_mask = 48'h0000_8020_0003;
         3'd4:    tap_mask = 48'h00A0_0014_0000;
         3'd5:    tap_mask = 48'hC000_0018_0000;
         default: tap_mask = 48'h0000_0000_00B8;
      endcase
   endfunction

   function automatic logic [MAXW-1:0] len_mask_f(input logic [2:0] cfg);
      case (cfg)
         3'd0:    len_mask_f = 48'h0000_0000_00FF;
         3'd1:    len_mask_f = 48'h0000_0000_FFFF;
         3'd2:    len_mask_f = 48'h0000_00FF_FFFF;
         3'd3:    len_mask_f = 48'h0000_FFFF_FFFF;
         3'd4:    len_mask_f = 48'h00FF_FFFF_FFFF;
         3'd5:    len_mask_f = 48'hFFFF_FFFF_FFFF;
         default: len_mask_f = 48'h0000_0000_00FF;
      endcase
   endfunction

   function automatic logic [MAXW-1:0] msb_mask_f(input logic [2:0] cfg);
      case (cfg)
         3'd0:    msb_mask_f = 48'h0000_0000_0080;
         3'd1:    msb_mask_f = 48'h0000_0000_8000;
         3'd2:    msb_mask_f = 48'h0000_0080_0000;
         3'd3:    msb_mask_f = 48'h0000_8000_0000;
         3'd4:    msb_mask_f = 48'h0080_0000_0000;
         3'd5:    msb_mask_f = 48'h8000_0000_0000;
         default: msb_mask_f = 48'h0000_0000_0080;
      endcase
   endfunction

endpackage

// File: rtl/alfsr_gen_fb.sv
// Combinational feedback bit and active-length mask for the current configuration.
module alfsr_gen_fb
   import alfsr_pkg::*;
(
   input  logic [MAXW-1:0] s,
   input  logic [2:0]      cfg,
   output logic            fb,
   output logic [MAXW-1:0] len_mask
);

   assign fb       = ^(s & tap_mask(cfg));
   assign len_mask = len_mask_f(cfg);

endmodule

// File: rtl/alfsr_gen.sv
// Block-configurable Fibonacci LFSR (8..48 bits) with load/seed, wrap detection
// and a sticky invalid-configuration flag. fsm_state exposes the control FSM.
module alfsr_gen
   import alfsr_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            load,
   input  logic [2:0]      blks,
   input  logic [MAXW-1:0] seed,
   output logic [MAXW-1:0] q,
   output logic            bit_out,
   output logic            valid,
   output logic            wrap,
   output logic            error,
   output state_e          fsm_state
);

   logic [MAXW-1:0] s;
   logic [MAXW-1:0] start;
   logic [2:0]      cfg;
   state_e          state;
   logic            fb;
   logic [MAXW-1:0] len_mask;
   logic [MAXW-1:0] s_step;
   logic [MAXW-1:0] load_val;
   logic            blks_ok;

   alfsr_gen_fb u_fb (
      .s        (s),
      .cfg      (cfg),
      .fb       (fb),
      .len_mask (len_mask)
   );

   assign s_step  = {s[MAXW-2:0], fb} & len_mask;
   assign blks_ok = (blks <= 3'd5);

   // An all-zero state would lock the register up, so it is replaced by 1.
   always_comb begin
      load_val = seed & len_mask_f(blks);
      if (load_val == '0) load_val = MAXW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s       <= MAXW'(1);
         start   <= MAXW'(1);
         cfg     <= 3'd0;
         state   <= IDLE;
         bit_out <= 1'b0;
         valid   <= 1'b0;
         wrap    <= 1'b0;
         error   <= 1'b0;
      end else begin
         valid <= 1'b0;
         wrap  <= 1'b0;
         if (load) begin
            if (blks_ok) begin
               cfg   <= blks;
               s     <= load_val;
               start <= load_val;
               error <= 1'b0;
               state <= RUN;
            end else begin
               error <= 1'b1;
            end
         end else if (state == RUN && en) begin
            s       <= s_step;
            valid   <= 1'b1;
            bit_out <= |(s_step & msb_mask_f(cfg));
            wrap    <= (s_step == start);
         end
      end
   end

   assign q         = s;
   assign fsm_state = state;

endmodule

// File: doc/alfsr_gen.md
Name: alfsr_gen

Overview:
Block-configurable Fibonacci LFSR. It generates the pseudo-random stream that feeds the block counter's enable path. Active register length is selected by a 3-bit block count: 1 to 6 blocks of 8 bits each, giving 8 to 48 bits. On the block-count input it raises the same invalid-configuration flag as the rest of the design (block count > 5). It emits a wrap pulse when the sequence returns to its seed, which the downstream counter and global reset logic consume.

Parameters:
BLK_W, 8, bits per block; the tap table is defined only for 8.
NBLK, 6, maximum number of blocks; state width = BLK_W*NBLK = 48.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
en  in  1  advance one step per cycle while RUN
load  in  1  latch blks and seed; enter RUN
blks  in  3  number of blocks minus 1 (0..5 valid); sampled only on load
seed  in  48  initial state; only the low L bits are used
q  out  48  current state; bits at and above L read 0
bit_out  out  1  MSB (bit L-1) of the state after the most recent step
valid  out  1  one-cycle pulse: a step occurred at the last edge
wrap  out  1  one-cycle pulse: the last step returned the state to the seed
error  out  1  last load attempt had blks > 5; sticky until next valid load or rst

Behaviour:
- L = 8*(cfg+1). cfg is the registered copy of blks, 3 bits, reset value 0.
- Taps, 1-based bit positions, all maximal-length:
  - L=8: 8,6,5,4
  - L=16: 16,15,13,4
  - L=24: 24,23,22,17
  - L=32: 32,22,2,1
  - L=40: 40,38,21,19
  - L=48: 48,47,21,20
- fb = XOR of the tapped state bits.
- Step: s[L-1:0] <= {s[L-2:0], fb}; s[47:L] <= 0.
- FSM states:
  - IDLE: after rst; en ignored; valid = 0.
  - RUN: entered by a good load; remains until rst; a later load re-seeds.
- Reset values: s = 48'h1; start = 48'h1; cfg = 0; state = IDLE; q = 1; bit_out = 0; valid = 0; wrap = 0; error = 0.
- Load with blks <= 5:
  - cfg <= blks.
  - s <= seed masked to L. If the masked seed is all zero, s <= 1 (lock-up guard).
  - start <= same value as s.
  - error <= 0; state <= RUN; valid <= 0 and wrap <= 0 that cycle.
- Load with blks > 5:
  - error <= 1.
  - s, cfg, start and FSM state are all unchanged; no step occurs even if en = 1.
- Step timing: at an edge with RUN, en = 1 and load = 0, the state steps.
  - Same edge: valid <= 1; bit_out <= new s[L-1]; wrap <= (new s == start).
  - Latency is one cycle from en to valid.
- With en = 0 in RUN: s holds, valid <= 0, wrap <= 0, bit_out holds.
- Priority: rst > load > en.
- q is driven directly from s; it is always zero above L and never all-zero.
- Changing blks without load has no effect.
- rst mid-sequence returns to IDLE with the reset values above on the next edge.
- Period is 2^L - 1 steps: wrap fires on step 255 for L=8 and every 65535 steps for L=16.

Decomposition:
- Shared package alfsr_pkg:
  - constants BLK_W = 8, NBLK = 6, MAXW = 48;
  - 6-entry tap mask table (48-bit masks indexed by cfg);
  - FSM state enum {IDLE, RUN}.
- One sub-module, alfsr_fb: combinational fb = ^(s & tapmask[cfg]) plus the length mask generator. The top level holds the FSM, registers and load logic.

Test Plan:
- Reset then en=1 for 10 cycles with no load → valid stays 0, q = 1, error = 0.
- load, blks=0, seed=8'h01, then en=1 continuously → valid on each following cycle; q visits 255 distinct non-zero values; wrap pulses exactly on step 255 and again on step 510.
- load, blks=1, seed=0 → q = 1 (lock-up guard); after 65535 steps wrap = 1; q[47:16] stays 0 throughout.
- During RUN with L=16, load with blks=6 → error = 1, q/cfg unchanged, no step that cycle; a following load with blks=5 and seed=48'hA5A5... → error = 0, L = 48.
- load and en asserted together → load wins; q = masked seed, valid = 0. Then en toggled 1/0/1 → valid pulses only on enabled edges, and bit_out matches q[L-1].
- rst asserted mid-run at step 100 → next cycle q = 1, valid = 0, wrap = 0, state IDLE; en ignored until the next load.
